// File: rtl/spi_reg_master_pkg.sv
// Shared definitions for the SPI register master: FSM states and header layout.
package spi_reg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DESEL = 3'd5
  } state_e;

  localparam int unsigned REG_W      = 7;
  localparam int unsigned HDR_WR_BIT = 7;

endpackage

// File: rtl/spi_reg_master_clkgen.sv
// SCK timing: half-period counter producing one-clk rise/fall strobes while enabled.
module spi_reg_master_clkgen
  import spi_reg_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] TOP = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == TOP) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign rise = en && !phase && (cnt == TOP);
  assign fall = en &&  phase && (cnt == TOP);

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 register master: header byte {write, reg} then data bytes in one ss frame.
// Optional multi-byte bursts are enabled with `define SPI_REG_MASTER_BURST_EN.
module spi_reg_master
  import spi_reg_master_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SS_SETUP = 4,
  parameter int unsigned BYTE_GAP = 4,
  parameter int unsigned SS_IDLE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [REG_W-1:0] cmd_reg,
  input  logic [7:0]       cmd_wdata,
  input  logic [3:0]       cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             ss,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  localparam logic [15:0] SETUP_END = 16'(SS_SETUP - 1);
  localparam logic [15:0] GAP_END   = 16'(BYTE_GAP - 1);
  // IDLE supplies the final ss-high cycle, so DESEL is one short of SS_IDLE.
  localparam logic [15:0] DESEL_END = 16'(SS_IDLE - 2);

  state_e      state, state_nx;
  logic [15:0] tmr;
  logic        rdy_en;
  logic [7:0]  sh, hdr, nxt;
  logic [2:0]  bit_cnt;
  logic [3:0]  byte_cnt, len_q;
  logic        in_data, wr_q, have_wr;
  logic [7:0]  wdata_q, wrd_q;
  logic        rx_pend, rx_last_pend;
  logic        rise, fall, need_wr, last_byte;

  spi_reg_master_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == ST_SHIFT),
    .rise (rise),
    .fall (fall)
  );

  assign cmd_ready = (state == ST_IDLE) && rdy_en;
  assign busy      = (state != ST_IDLE);
  assign last_byte = in_data && (byte_cnt == len_q);

`ifdef SPI_REG_MASTER_BURST_EN
  assign need_wr  = wr_q && in_data && (byte_cnt != 4'd0);
  assign wr_ready = (state == ST_GAP) && need_wr && !have_wr;
`else
  logic unused_burst;
  assign unused_burst = ^{cmd_len, wr_valid, wr_data};
  assign need_wr      = 1'b0;
  assign wr_ready     = 1'b0;
`endif

  always_comb begin
    hdr                = '0;
    hdr[HDR_WR_BIT]    = cmd_write;
    hdr[REG_W-1:0]     = cmd_reg;
    nxt                = '0;
    if (wr_q) nxt = (byte_cnt == 4'd0) ? wdata_q : wrd_q;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (cmd_valid && cmd_ready) state_nx = ST_SETUP;
      ST_SETUP: if (tmr == SETUP_END) state_nx = ST_SHIFT;
      ST_SHIFT: if (fall && bit_cnt == 3'd0) state_nx = last_byte ? ST_HOLD : ST_GAP;
      ST_GAP:   if (tmr >= GAP_END && !(need_wr && !have_wr)) state_nx = ST_SHIFT;
      ST_HOLD:  if (tmr == SETUP_END) state_nx = ST_DESEL;
      ST_DESEL: if (tmr >= DESEL_END) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) tmr <= '0;
      else if (tmr != '1)    tmr <= tmr + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en       <= 1'b0;
      ss           <= 1'b1;
      sck          <= 1'b0;
      mosi         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_last     <= 1'b0;
      sh           <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      len_q        <= '0;
      in_data      <= 1'b0;
      wr_q         <= 1'b0;
      have_wr      <= 1'b0;
      wdata_q      <= '0;
      wrd_q        <= '0;
      rx_pend      <= 1'b0;
      rx_last_pend <= 1'b0;
    end else begin
      rdy_en    <= 1'b1;
      rsp_valid <= rx_pend;
      rsp_last  <= rx_pend && rx_last_pend;
      rx_pend   <= 1'b0;
      if (rx_pend) rsp_data <= sh;
      case (state)
        ST_IDLE: if (cmd_valid && cmd_ready) begin
          ss       <= 1'b0;
          wr_q     <= cmd_write;
          sh       <= hdr;
          mosi     <= hdr[7];
          wdata_q  <= cmd_wdata;
`ifdef SPI_REG_MASTER_BURST_EN
          len_q    <= cmd_len;
`else
          len_q    <= '0;
`endif
          in_data  <= 1'b0;
          byte_cnt <= '0;
          bit_cnt  <= '0;
          have_wr  <= 1'b0;
        end
        ST_SHIFT: begin
          if (rise) begin
            sck     <= 1'b1;
            sh      <= {sh[6:0], miso};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7 && in_data && !wr_q) begin
              rx_pend      <= 1'b1;
              rx_last_pend <= last_byte;
            end
          end else if (fall) begin
            sck <= 1'b0;
            if (bit_cnt != 3'd0) begin
              mosi <= sh[7];
            end else begin
              mosi    <= 1'b0;
              in_data <= 1'b1;
              if (in_data && !last_byte) byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        ST_GAP: begin
`ifdef SPI_REG_MASTER_BURST_EN
          if (wr_ready && wr_valid) begin
            wrd_q   <= wr_data;
            have_wr <= 1'b1;
          end
`endif
          // Next byte is loaded on leaving GAP so a late burst write byte is picked up.
          if (state_nx == ST_SHIFT) begin
            sh      <= nxt;
            mosi    <= nxt[7];
            bit_cnt <= '0;
            have_wr <= 1'b0;
          end
        end
        ST_HOLD: if (state_nx == ST_DESEL) ss <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_reg_master.md
SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per sck half-period; minimum 2.
REQ-002 Parameter SS_SETUP, default 4: clk cycles between ss falling and the first sck rising edge, and between the last sck falling edge and ss rising.
REQ-003 Parameter BYTE_GAP, default 4: clk cycles of idle sck (low) between bytes within a frame; minimum 4.
REQ-004 Parameter SS_IDLE, default 4: minimum clk cycles ss stays high between frames.
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  high in IDLE only; command accepted on cmd_valid && cmd_ready.
REQ-009 cmd_write  in  1  1 = register write, 0 = register read.
REQ-010 cmd_reg  in  7  register number.
REQ-011 cmd_wdata  in  8  first (or only) write data byte.
REQ-012 cmd_len  in  4  data bytes minus one (burst build only; see REQ-030).
REQ-013 wr_valid / wr_ready  in / out  1 / 1  burst write data handshake for bytes 2..N; wr_data in 8.
REQ-014 rsp_valid  out  1  one-clk pulse per received read byte; rsp_data out 8; rsp_last out 1 marks final byte.
REQ-015 busy  out  1  high whenever not IDLE.
REQ-016 ss  out  1  active-low slave select; sck  out  1; mosi  out  1; miso  in  1.

Function
REQ-017 SPI mode 0: sck idles low, mosi changes on falling edge (first bit before first rising edge), miso sampled on rising edge, MSB first.
REQ-018 Frame: byte 0 = {cmd_write, cmd_reg}; then data bytes, all within one ss-low period.
REQ-019 Write: data bytes driven on mosi; miso ignored; no rsp_valid.
REQ-020 Read: mosi drives 0x00 on data bytes; each data byte received from miso emitted on rsp_data with rsp_valid one clk after its 8th sampling edge.
REQ-021 States: IDLE -> SETUP (ss low, SS_SETUP clks) -> SHIFT (8 sck periods) -> GAP (BYTE_GAP clks) -> SHIFT ... -> HOLD (SS_SETUP clks after last byte) -> DESEL (ss high, SS_IDLE clks) -> IDLE.
REQ-022 All command fields latched at acceptance; input changes afterwards are ignored.
REQ-023 Bit counter 3 bits, byte counter 4 bits; frame ends after byte counter reaches latched length.
REQ-024 Back-to-back commands: cmd_valid held high produces frames separated by exactly SS_IDLE clks of ss high.
REQ-025 rsp_last asserted only with the final rsp_valid of a read frame.

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, ss=1, sck=0, mosi=0, cmd_ready=0 until first clk after release then 1, rsp_valid=0, rsp_data=0, rsp_last=0, wr_ready=0, busy=0.
REQ-027 Reset mid-frame aborts it with no further rsp_valid; the slave sees ss rise, which resets its frame state.

Configuration
REQ-028 Macro SPI_REG_MASTER_BURST_EN.
REQ-029 Without it: cmd_len ignored, every frame is exactly 2 bytes; wr_ready tied 0.
REQ-030 With it: frame carries cmd_len+1 data bytes (1..16) to the same register; for writes, before bytes 2..N the master asserts wr_ready in GAP and waits there with ss low and sck low until wr_valid; wr_data latched on handshake.

Structure
REQ-031 Shared package holds the state enumeration, the header bit position (write flag = bit 7) and register-number width 7.
REQ-032 One sub-module, spi_reg_master_clkgen: half-period counter generating one-clk rise/fall strobes, enabled only in SHIFT.

Verification
REQ-033 CLK_DIV=2, read reg 0x05, slave model returns 0xA5 -> mosi bytes 0x05, 0x00; one rsp_valid, rsp_data=0xA5, rsp_last=1.
REQ-034 Write reg 0x12 data 0x3C -> mosi bytes 0x92, 0x3C; 16 sck rising edges; no rsp_valid; busy falls after DESEL.
REQ-035 Burst build, read reg 0x20 cmd_len=2, slave returns 0x11,0x22,0x33 -> three rsp_valid in order, rsp_last only on 0x33.
REQ-036 Burst write cmd_len=1, wr_valid delayed 20 clks -> ss held low and sck low for the delay; second byte sent after handshake.
REQ-037 rst_n asserted during bit 3 of byte 1 -> ss=1, sck=0 immediately; no rsp_valid; next command completes normally.
REQ-038 Two commands with cmd_valid held high -> ss high exactly SS_IDLE clks between frames.
